kbd_event_ctrl: RTL and testbench

KBD_EVENT_CTRL -- requirements
Module: kbd_event_ctrl

---
 rtl/kbd_event_ctrl_pkg.sv | 32 +++
 rtl/kbd_event_ctrl_if.sv | 10 +
 rtl/kbd_event_ctrl_fifo.sv | 69 ++++++
 rtl/kbd_event_ctrl.sv | 84 ++++++++
 tb/tb_kbd_event_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/kbd_event_ctrl_pkg.sv
// Shared types and mapped key codes for the keyboard event controller.
package kbd_ctrl_pkg;

    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_LEFT  = 9'h16B;
    localparam logic [8:0] KEY_RIGHT = 9'h174;
    localparam int         NUM_KEYS  = 4;

    typedef struct packed {
        logic [8:0] code;
        logic       is_make;
    } kbd_event_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_MAKE  = 2'd1,
        EV_BRAKE = 2'd2
    } ev_kind_e;

    // One-hot match of a scan code against the mapped keys, bit order UP, DOWN, LEFT, RIGHT.
    function automatic logic [NUM_KEYS-1:0] key_match(input logic [8:0] code);
        logic [NUM_KEYS-1:0] hit;
        hit    = '0;
        hit[0] = (code == KEY_UP);
        hit[1] = (code == KEY_DOWN);
        hit[2] = (code == KEY_LEFT);
        hit[3] = (code == KEY_RIGHT);
        return hit;
    endfunction

endpackage

// File: rtl/kbd_event_ctrl_if.sv
// Consumer-side handshake for queued keyboard events.
interface kbd_event_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [8:0] ev_code;
    logic       ev_make;

    modport master (output ev_valid, output ev_code, output ev_make, input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_make, output ev_ready);
endinterface

// File: rtl/kbd_event_ctrl_fifo.sv
// Event FIFO: power-of-two depth, naturally wrapping pointers, exact occupancy count.
module kbd_event_fifo
    import kbd_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  kbd_event_t             push_data_i,
    output logic                   push_accept_o,
    input  logic                   pop_i,
    output kbd_event_t             head_o,
    output logic                   head_valid_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    kbd_event_t      mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            pop_ok;
    logic            push_ok;

    assign head_valid_o  = (count_q != '0);
    assign count_o       = count_q;
    assign head_o        = head_valid_o ? mem_q[rd_ptr_q] : '0;
    assign push_accept_o = push_ok;

    // Handshake qualification; a full queue still accepts when the head leaves this cycle.
    always_comb begin
        pop_ok   = pop_i & head_valid_o & ~flush_i;
        push_ok  = push_i & ~flush_i & ((count_q < CW'(DEPTH)) | pop_ok);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; flush behaves like a local reset.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/kbd_event_ctrl.sv
// Keyboard event controller: classifies make/brake pulses, filters typematic
// repeats of held mapped keys, tracks held state and queues events for a consumer.
module kbd_event_ctrl
    import kbd_ctrl_pkg::*;
#(
    parameter int DEPTH           = 8,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic [8:0]             key_Pressed,
    input  logic                   make,
    input  logic                   brake,
    input  logic                   flush,
    kbd_event_if.master            ev_if,
    output logic [NUM_KEYS-1:0]    held,
    output logic [$clog2(DEPTH):0] ev_count,
    output logic                   overflow,
    input  logic                   ovf_clear
);
    ev_kind_e            ev_kind;
    logic [NUM_KEYS-1:0] key_hit;
    logic                repeat_drop;
    logic                push;
    logic                pop;
    logic                push_accept;
    logic                head_valid;
    kbd_event_t          push_data;
    kbd_event_t          head;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic                overflow_q, overflow_d;

    // Classification, repeat filter, held-table and sticky overflow next-state.
    always_comb begin
        ev_kind = EV_NONE;
        if (brake)     ev_kind = EV_BRAKE;
        else if (make) ev_kind = EV_MAKE;

        key_hit     = key_match(key_Pressed);
        repeat_drop = SUPPRESS_REPEAT && (ev_kind == EV_MAKE) && ((key_hit & held_q) != '0);
        push        = (ev_kind != EV_NONE) && !repeat_drop && !flush;
        push_data   = '{code: key_Pressed, is_make: (ev_kind == EV_MAKE)};
        pop         = head_valid & ev_if.ev_ready;

        held_d = held_q;
        if (flush)                      held_d = '0;
        else if (ev_kind == EV_MAKE)    held_d = held_q | key_hit;
        else if (ev_kind == EV_BRAKE)   held_d = held_q & ~key_hit;

        overflow_d = overflow_q | (push & ~push_accept);
        if (ovf_clear) overflow_d = 1'b0;
    end

    // Held table and overflow flag registers.
    always_ff @(posedge clk) begin
        if (resetN) begin
            held_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            held_q     <= held_d;
            overflow_q <= overflow_d;
        end
    end

    kbd_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (resetN),
        .flush_i      (flush),
        .push_i       (push),
        .push_data_i  (push_data),
        .push_accept_o(push_accept),
        .pop_i        (pop),
        .head_o       (head),
        .head_valid_o (head_valid),
        .count_o      (ev_count)
    );

    assign ev_if.ev_valid = head_valid;
    assign ev_if.ev_code  = head.code;
    assign ev_if.ev_make  = head.is_make;
    assign held           = held_q;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Directed bench for kbd_event_ctrl: a vector table plus overflow/full-queue sequences.
module tb_kbd_event_ctrl;
    import kbd_ctrl_pkg::*;

    typedef struct {
        logic       mk;
        logic       br;
        logic [8:0] code;
        logic       rdy;
        logic       fl;
        logic       rst;
        logic       ovc;
        logic       e_valid;
        logic [8:0] e_code;
        logic       e_make;
        logic [3:0] e_held;
        logic [3:0] e_count;
        logic       e_ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic [8:0] key_Pressed = '0;
    logic       make = 1'b0;
    logic       brake = 1'b0;
    logic       flush = 1'b0;
    logic       ovf_clear = 1'b0;
    logic [3:0] held;
    logic [3:0] ev_count;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    kbd_event_if ev_bus ();

    kbd_event_ctrl #(.DEPTH(8), .SUPPRESS_REPEAT(1'b1)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .key_Pressed(key_Pressed),
        .make       (make),
        .brake      (brake),
        .flush      (flush),
        .ev_if      (ev_bus.master),
        .held       (held),
        .ev_count   (ev_count),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input logic mk, input logic br, input logic [8:0] code,
                        input logic rdy, input logic fl, input logic rst, input logic ovc);
        make            = mk;
        brake           = br;
        key_Pressed     = code;
        ev_bus.ev_ready = rdy;
        flush           = fl;
        resetN          = rst;
        ovf_clear       = ovc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic v, input logic [8:0] c, input logic m,
                       input logic [3:0] h, input logic [3:0] n, input logic o);
        n_vec++;
        if (ev_bus.ev_valid !== v || ev_bus.ev_code !== c || ev_bus.ev_make !== m ||
            held !== h || ev_count !== n || overflow !== o) begin
            n_err++;
            $display("FAIL %s: got valid=%0b code=%h make=%0b held=%b count=%0d ovf=%0b, expected valid=%0b code=%h make=%0b held=%b count=%0d ovf=%0b",
                     tag, ev_bus.ev_valid, ev_bus.ev_code, ev_bus.ev_make, held, ev_count, overflow,
                     v, c, m, h, n, o);
        end
    endtask

    task automatic add(input logic mk, input logic br, input logic [8:0] code, input logic rdy,
                       input logic fl, input logic rst, input logic ovc,
                       input logic v, input logic [8:0] c, input logic m,
                       input logic [3:0] h, input logic [3:0] n, input logic o);
        vec_t t;
        t = '{mk, br, code, rdy, fl, rst, ovc, v, c, m, h, n, o};
        vecs.push_back(t);
    endtask

    initial begin
        logic [8:0] drain_exp [8];

        ev_bus.ev_ready = 1'b0;

        //   mk br code    rdy fl rst ovc | valid code    mk held     cnt ovf
        add(1, 0, 9'h175, 1, 0, 1, 0,      0, 9'h000, 0, 4'b0000, 0, 0); // reset dominates
        add(1, 0, 9'h175, 0, 0, 0, 0,      1, 9'h175, 1, 4'b0001, 1, 0); // first make
        add(1, 0, 9'h175, 0, 0, 0, 0,      1, 9'h175, 1, 4'b0001, 1, 0); // repeat dropped
        add(1, 0, 9'h175, 0, 0, 0, 0,      1, 9'h175, 1, 4'b0001, 1, 0); // repeat dropped
        add(0, 1, 9'h175, 0, 0, 0, 0,      1, 9'h175, 1, 4'b0000, 2, 0); // brake queued
        add(0, 0, 9'h000, 1, 0, 0, 0,      1, 9'h175, 0, 4'b0000, 1, 0); // pop make
        add(0, 0, 9'h000, 1, 0, 0, 0,      0, 9'h000, 0, 4'b0000, 0, 0); // pop brake
        add(1, 0, 9'h16B, 1, 0, 0, 0,      1, 9'h16B, 1, 4'b0100, 1, 0); // push at empty, no bypass
        add(1, 1, 9'h16B, 0, 0, 0, 0,      1, 9'h16B, 1, 4'b0000, 2, 0); // make+brake -> brake
        add(1, 0, 9'h172, 1, 0, 0, 0,      1, 9'h16B, 0, 4'b0010, 2, 0); // push+pop
        add(1, 0, 9'h174, 0, 0, 0, 0,      1, 9'h16B, 0, 4'b1010, 3, 0);
        add(1, 0, 9'h01C, 0, 0, 0, 0,      1, 9'h16B, 0, 4'b1010, 4, 0); // unmapped make
        add(0, 1, 9'h01C, 0, 0, 0, 0,      1, 9'h16B, 0, 4'b1010, 5, 0); // unmapped brake
        add(1, 0, 9'h174, 1, 1, 0, 0,      0, 9'h000, 0, 4'b0000, 0, 0); // flush wins
        add(0, 0, 9'h000, 0, 0, 0, 0,      0, 9'h000, 0, 4'b0000, 0, 0);
        add(1, 0, 9'h174, 0, 0, 0, 0,      1, 9'h174, 1, 4'b1000, 1, 0); // held was cleared
        add(1, 0, 9'h175, 1, 0, 1, 0,      0, 9'h000, 0, 4'b0000, 0, 0); // mid-stream reset
        add(0, 0, 9'h000, 0, 0, 0, 0,      0, 9'h000, 0, 4'b0000, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].mk, vecs[i].br, vecs[i].code, vecs[i].rdy, vecs[i].fl, vecs[i].rst, vecs[i].ovc);
            chk($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_code, vecs[i].e_make,
                vecs[i].e_held, vecs[i].e_count, vecs[i].e_ovf);
        end

        // Nine unmapped makes into a depth-8 queue: the ninth is dropped.
        for (int i = 1; i <= 9; i++) begin
            step(1, 0, 9'(i), 0, 0, 0, 0);
            chk($sformatf("fill%0d", i), 1, 9'h001, 1, 4'b0000, (i > 8) ? 4'd8 : 4'(i), (i == 9));
        end
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 9'h000, 1, 0, 0, 0);
            if (i < 8) chk($sformatf("drain%0d", i), 1, 9'(i + 1), 1, 4'b0000, 4'(8 - i), 1);
            else       chk("drain_empty", 0, 9'h000, 0, 4'b0000, 0, 1);
        end
        step(0, 0, 9'h000, 0, 0, 0, 1);
        chk("ovf_clear", 0, 9'h000, 0, 4'b0000, 0, 0);

        // Refill, then overflow attempt with same-cycle clear, then full push+pop.
        for (int i = 0; i < 8; i++) step(1, 0, 9'h010 + 9'(i), 0, 0, 0, 0);
        chk("refill", 1, 9'h010, 1, 4'b0000, 8, 0);
        step(1, 0, 9'h018, 0, 0, 0, 1);
        chk("clear_prio", 1, 9'h010, 1, 4'b0000, 8, 0);
        step(1, 0, 9'h019, 1, 0, 0, 0);
        chk("full_push_pop", 1, 9'h011, 1, 4'b0000, 8, 0);

        for (int k = 0; k < 7; k++) drain_exp[k] = 9'h011 + 9'(k);
        drain_exp[7] = 9'h019;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("order%0d", k), 1, drain_exp[k], 1, 4'b0000, 4'(8 - k), 0);
            step(0, 0, 9'h000, 1, 0, 0, 0);
        end
        chk("final_empty", 0, 9'h000, 0, 4'b0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
